// File: rtl/rand_server.sv
// rand_server: round-robin sharing of one 8-bit LFSR with per-requester range reduction
//   Clk        system clock
//   Reset      synchronous active-high reset
//   Req        level request, one bit per requester
//   Req_range  8-bit range per requester, captured at grant
//   Rand_num   current LFSR output
//   Rng_start  generator Start, 0 loads the seed
//   Ack        one-hot, one-cycle result strobe
//   Rand_out   reduced random value, held until the next Ack
//   Busy       high in every state except IDLE
module rand_server #(
    parameter int N_REQ = 4,
    parameter int MAX_TRIES = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [N_REQ-1:0]   Req,
    input  logic [N_REQ*8-1:0] Req_range,
    input  logic [7:0]         Rand_num,
    output logic               Rng_start,
    output logic [N_REQ-1:0]   Ack,
    output logic [7:0]         Rand_out,
    output logic               Busy
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    typedef enum logic [1:0] {INIT, IDLE, SAMPLE, DONE} state_t;
    state_t state, state_nx;
    logic [IW-1:0] ptr, win, pick, j;
    logic [7:0] rng, mask, sel_range, sel_mask, v, result_nx;
    logic [3:0] tries, tries_nx;
    int idx;
    always_comb begin
        pick = ptr;
        idx = 0;
        j = '0;
        // descending scan so the lowest offset from the pointer wins
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            j = IW'(idx);
            if (Req[j]) pick = j;
        end
        sel_range = Req_range[{pick, 3'b000} +: 8];
        // smear R-1 rightwards to get the smallest all-ones mask covering it
        sel_mask = sel_range - 8'd1;
        sel_mask = sel_mask | (sel_mask >> 1);
        sel_mask = sel_mask | (sel_mask >> 2);
        sel_mask = sel_mask | (sel_mask >> 4);
    end
    always_comb begin
        state_nx = state;
        tries_nx = tries;
        result_nx = Rand_out;
        v = Rand_num & mask;
        case (state)
            INIT: state_nx = IDLE;
            IDLE: begin
                if (|Req) begin
                    state_nx = SAMPLE;
                    tries_nx = '0;
                end
            end
            SAMPLE: begin
                if (rng == 8'd0) begin
                    result_nx = 8'd0;
                    state_nx = DONE;
                end else if (v < rng) begin
                    result_nx = v;
                    state_nx = DONE;
                end else if (tries == 4'(MAX_TRIES - 1)) begin
                    // v <= mask < 2*rng, so v - rng is always in range
                    result_nx = v - rng;
                    state_nx = DONE;
                end else begin
                    tries_nx = tries + 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= INIT;
            Rng_start <= 1'b0;
            Ack <= '0;
            Rand_out <= 8'd0;
            Busy <= 1'b1;
            ptr <= '0;
            win <= '0;
            rng <= 8'd0;
            mask <= 8'd0;
            tries <= '0;
        end else begin
            state <= state_nx;
            tries <= tries_nx;
            Rng_start <= 1'b1;
            Busy <= state_nx != IDLE;
            Ack <= (state_nx == DONE) ? {{(N_REQ-1){1'b0}}, 1'b1} << win : '0;
            Rand_out <= (state_nx == DONE) ? result_nx : Rand_out;
            if (state == IDLE && |Req) begin
                win <= pick;
                rng <= sel_range;
                mask <= sel_mask;
            end
            if (state == DONE) ptr <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
        end
    end
endmodule
